// File: rtl/i281_program_loader.sv
// Writes switch-entered instruction words into i281 code memory, one per debounced
// button press, while holding the CPU; pulses a PC clear on leaving load mode.
module i281_program_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ADDR_W          = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_mode,
    input  logic              load_btn,
    input  logic [15:0]       inp,
    output logic [ADDR_W-1:0] cmem_addr,
    output logic [15:0]       cmem_data,
    output logic              cmem_we,
    output logic              cpu_hold,
    output logic              pc_clear,
    output logic [ADDR_W:0]   word_count,
    output logic              full
);

    localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W:0]  DEPTH   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        EXIT  = 2'd3
    } state_t;

    state_t            state_q;
    logic              lm_s1_q, lm_s2_q;
    logic              btn_s1_q, btn_s2_q;
    logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
    logic              db_lvl_q, db_lvl_d;
    logic              db_lvl_prev_q;
    logic              strobe;
    logic [ADDR_W-1:0] cmem_addr_q;
    logic [15:0]       cmem_data_q;
    logic              cmem_we_q;
    logic              cpu_hold_q;
    logic              pc_clear_q;
    logic [ADDR_W:0]   word_count_q;
    logic [ADDR_W:0]   word_count_inc;
    logic              full_q;

    // Counter restarts on any sample agreeing with the accepted level, so only
    // an uninterrupted run of DEBOUNCE_CYCLES differing samples flips it.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (btn_s2_q != db_lvl_q) begin
            if (db_cnt_q == CNT_MAX) begin
                db_lvl_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign strobe         = db_lvl_q & ~db_lvl_prev_q;
    assign word_count_inc = word_count_q + (ADDR_W + 1)'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            lm_s1_q       <= 1'b0;
            lm_s2_q       <= 1'b0;
            btn_s1_q      <= 1'b0;
            btn_s2_q      <= 1'b0;
            db_cnt_q      <= '0;
            db_lvl_q      <= 1'b0;
            db_lvl_prev_q <= 1'b0;
        end else begin
            lm_s1_q       <= load_mode;
            lm_s2_q       <= lm_s1_q;
            btn_s1_q      <= load_btn;
            btn_s2_q      <= btn_s1_q;
            db_cnt_q      <= db_cnt_d;
            db_lvl_q      <= db_lvl_d;
            db_lvl_prev_q <= db_lvl_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cmem_addr_q  <= '0;
            cmem_data_q  <= '0;
            cmem_we_q    <= 1'b0;
            cpu_hold_q   <= 1'b0;
            pc_clear_q   <= 1'b0;
            word_count_q <= '0;
            full_q       <= 1'b0;
        end else begin
            cmem_we_q  <= 1'b0;
            pc_clear_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cpu_hold_q <= 1'b0;
                    if (lm_s2_q) begin
                        state_q      <= LOAD;
                        cpu_hold_q   <= 1'b1;
                        cmem_addr_q  <= '0;
                        word_count_q <= '0;
                        full_q       <= 1'b0;
                    end
                end
                LOAD: begin
                    // Leaving load mode wins over a coincident press.
                    if (!lm_s2_q) begin
                        state_q    <= EXIT;
                        pc_clear_q <= 1'b1;
                    end else if (strobe && !full_q) begin
                        state_q     <= WRITE;
                        cmem_data_q <= inp;
                        cmem_we_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    state_q      <= LOAD;
                    cmem_addr_q  <= cmem_addr_q + ADDR_W'(1);
                    word_count_q <= word_count_inc;
                    if (word_count_inc == DEPTH) begin
                        full_q <= 1'b1;
                    end
                end
                EXIT: begin
                    state_q    <= IDLE;
                    cpu_hold_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmem_addr  = cmem_addr_q;
    assign cmem_data  = cmem_data_q;
    assign cmem_we    = cmem_we_q;
    assign cpu_hold   = cpu_hold_q;
    assign pc_clear   = pc_clear_q;
    assign word_count = word_count_q;
    assign full       = full_q;

endmodule

// File: tb/tb_i281_program_loader.sv
// Directed bench for i281_program_loader: vector table of single presses plus
// hand-written reset, bounce, exit, fill and reset-during-write sequences.
module tb_i281_program_loader;

    localparam int unsigned ADDR_W = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic              load_mode;
    logic              load_btn;
    logic [15:0]       inp;
    logic [ADDR_W-1:0] cmem_addr;
    logic [15:0]       cmem_data;
    logic              cmem_we;
    logic              cpu_hold;
    logic              pc_clear;
    logic [ADDR_W:0]   word_count;
    logic              full;

    i281_program_loader #(
        .DEBOUNCE_CYCLES(16),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_mode (load_mode),
        .load_btn  (load_btn),
        .inp       (inp),
        .cmem_addr (cmem_addr),
        .cmem_data (cmem_data),
        .cmem_we   (cmem_we),
        .cpu_hold  (cpu_hold),
        .pc_clear  (pc_clear),
        .word_count(word_count),
        .full      (full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]       inp;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W:0]   wc_after;
        logic [ADDR_W-1:0] addr_after;
    } vec_t;

    vec_t vecs[4];

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Write/pulse monitor, sampled mid-cycle.
    int unsigned we_cnt = 0;
    int unsigned pc_cnt = 0;
    int unsigned hold_seen = 0;
    logic        hold_at_pc = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [15:0]       last_data = '0;
    logic [15:0]       mem_data [64];
    int unsigned       mem_wr   [64];

    always @(negedge clock) begin
        if (cmem_we === 1'b1) begin
            we_cnt++;
            last_addr = cmem_addr;
            last_data = cmem_data;
            mem_data[cmem_addr] = cmem_data;
            mem_wr[cmem_addr]++;
        end
        if (pc_clear === 1'b1) begin
            pc_cnt++;
            hold_at_pc = cpu_hold;
        end
        if (cpu_hold === 1'b1) hold_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [15:0] value);
        inp = value;
        load_btn = 1'b1;
        cycles(40);
        load_btn = 1'b0;
        cycles(40);
    endtask

    int unsigned we0;
    int unsigned bad;
    bit          found;

    initial begin
        vecs[0] = '{inp: 16'hA3C5, addr: 6'd0, wc_after: 7'd1, addr_after: 6'd1};
        vecs[1] = '{inp: 16'hFFFF, addr: 6'd1, wc_after: 7'd2, addr_after: 6'd2};
        vecs[2] = '{inp: 16'h0000, addr: 6'd2, wc_after: 7'd3, addr_after: 6'd3};
        vecs[3] = '{inp: 16'h5A5A, addr: 6'd3, wc_after: 7'd4, addr_after: 6'd4};

        reset = 1'b1; load_mode = 1'b0; load_btn = 1'b0; inp = '0;
        cycles(2);
        reset = 1'b0;
        @(negedge clock);
        check("rst_addr", 32'(cmem_addr), 0);
        check("rst_data", 32'(cmem_data), 0);
        check("rst_we", 32'(cmem_we), 0);
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_pcclr", 32'(pc_clear), 0);
        check("rst_wc", 32'(word_count), 0);
        check("rst_full", 32'(full), 0);
        we_cnt = 0; hold_seen = 0;
        cycles(100);
        check("idle_no_we", we_cnt, 0);
        check("idle_no_hold", hold_seen, 0);

        // Enter load mode: two sync stages then LOAD one cycle later.
        load_mode = 1'b1;
        cycles(2);
        @(negedge clock);
        check("hold_early", 32'(cpu_hold), 0);
        cycles(2);
        @(negedge clock);
        check("hold_load", 32'(cpu_hold), 1);

        for (int i = 0; i < 4; i++) begin
            we0 = we_cnt;
            press(vecs[i].inp);
            check($sformatf("v%0d_we", i), we_cnt - we0, 1);
            check($sformatf("v%0d_addr", i), 32'(last_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d_data", i), 32'(last_data), 32'(vecs[i].inp));
            check($sformatf("v%0d_wc", i), 32'(word_count), 32'(vecs[i].wc_after));
            check($sformatf("v%0d_next", i), 32'(cmem_addr), 32'(vecs[i].addr_after));
        end

        // Bouncing press, then bouncing release.
        we0 = we_cnt;
        inp = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            load_btn = ~load_btn;
            cycles(3);
        end
        load_btn = 1'b1;
        cycles(40);
        check("bounce_we", we_cnt - we0, 1);
        check("bounce_data", 32'(last_data), 32'h1234);
        check("bounce_addr", 32'(last_addr), 4);
        for (int i = 0; i < 10; i++) begin
            load_btn = ~load_btn;
            cycles(3);
        end
        load_btn = 1'b0;
        cycles(40);
        check("release_no_we", we_cnt - we0, 1);
        check("bounce_wc", 32'(word_count), 5);

        // Exit load mode.
        pc_cnt = 0;
        load_mode = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            if (pc_clear === 1'b1) found = 1;
        end
        check("exit_pc_seen", 32'(found), 1);
        cycles(5);
        check("exit_pc_once", pc_cnt, 1);
        check("exit_hold_at_pc", 32'(hold_at_pc), 1);
        check("exit_hold_after", 32'(cpu_hold), 0);
        check("exit_wc_kept", 32'(word_count), 5);

        load_mode = 1'b1;
        cycles(5);
        check("reenter_wc", 32'(word_count), 0);
        check("reenter_addr", 32'(cmem_addr), 0);
        check("reenter_hold", 32'(cpu_hold), 1);

        // Fill all 64 words.
        for (int a = 0; a < 64; a++) mem_wr[a] = 0;
        for (int a = 0; a < 64; a++) press(16'(a));
        bad = 0;
        for (int a = 0; a < 64; a++) begin
            check($sformatf("fill_data_%0d", a), 32'(mem_data[a]), 32'(a));
            if (mem_wr[a] != 1) bad++;
        end
        check("fill_once_each", bad, 0);
        check("fill_full", 32'(full), 1);
        check("fill_wc", 32'(word_count), 64);
        check("fill_addr_wrap", 32'(cmem_addr), 0);
        we0 = we_cnt;
        press(16'hBEEF);
        check("full_no_we", we_cnt - we0, 0);
        check("full_kept", 32'(full), 1);

        // Reset during the write cycle.
        load_mode = 1'b0;
        cycles(10);
        load_mode = 1'b1;
        cycles(5);
        check("pre_rst_wc", 32'(word_count), 0);
        inp = 16'hC0DE;
        load_btn = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (cmem_we === 1'b1) found = 1;
        end
        check("midwr_we_seen", 32'(found), 1);
        reset = 1'b1; load_mode = 1'b0; load_btn = 1'b0;
        @(negedge clock);
        check("midwr_we", 32'(cmem_we), 0);
        check("midwr_wc", 32'(word_count), 0);
        check("midwr_addr", 32'(cmem_addr), 0);
        check("midwr_hold", 32'(cpu_hold), 0);
        check("midwr_data", 32'(cmem_data), 0);
        cycles(1);
        reset = 1'b0;
        we0 = we_cnt;
        cycles(30);
        check("post_rst_no_we", we_cnt - we0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
